// File: rtl/vector_divide_unit.sv
// Packed-SIMD restoring divider for one 64-bit slice: vdivu/vdiv/vremu/vrem on 8/16/32/64-bit lanes.
// Latency: SEW+1 edges from operand acceptance to result_valid (SEW steps plus one correction cycle).
// Backpressure: start_ready only in IDLE; vd/result_valid held in DONE until result_ready, then one bubble.
// Ports: clock/reset_n; start_valid/start_ready with sew, is_signed, want_remainder, vs2 (dividends),
//        vs1 (divisors); result_valid/result_ready with vd (packed results, lane i at [i*SEW +: SEW]).
module vector_divide_unit #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [1:0]            sew,
    input  logic                  is_signed,
    input  logic                  want_remainder,
    input  logic [DATA_WIDTH-1:0] vs2,
    input  logic [DATA_WIDTH-1:0] vs1,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] vd
);

    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH, DONE} state_t;

    state_t          state_q, state_d;
    logic [6:0]      cnt_q;
    logic [1:0]      sew_q;
    logic            wr_q;
    logic [DW-1:0]   rem_q;      // partial remainder magnitudes
    logic [DW-1:0]   quo_q;      // dividend magnitudes shifting out, quotient bits shifting in
    logic [DW-1:0]   div_q;      // divisor magnitudes
    logic [DW-1:0]   orig_q;     // raw dividend lanes for the div-by-zero / overflow results
    logic [7:0]      nq_q;       // negate quotient (dividend sign xor divisor sign)
    logic [7:0]      nr_q;       // negate remainder (dividend sign)
    logic [7:0]      dz_q;       // divisor lane is zero
    logic [7:0]      ov_q;       // signed most-negative / -1
    logic [DW-1:0]   vd_q;

    // One result per element width; the active width is picked by a mux afterwards.
    logic [DW-1:0]   abs_a_w [4];
    logic [DW-1:0]   abs_b_w [4];
    logic [7:0]      nq_w    [4];
    logic [7:0]      nr_w    [4];
    logic [7:0]      dz_w    [4];
    logic [7:0]      ov_w    [4];
    logic [DW-1:0]   step_rem_w [4];
    logic [DW-1:0]   step_quo_w [4];
    logic [DW-1:0]   fin_res_w  [4];

    function automatic logic [6:0] lane_bits(input logic [1:0] s);
        case (s)
            2'd0:    lane_bits = 7'd8;
            2'd1:    lane_bits = 7'd16;
            2'd2:    lane_bits = 7'd32;
            default: lane_bits = 7'd64;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_w
        localparam int W = 8 << g;
        localparam int N = DW / W;

        logic [DW-1:0] abs_a, abs_b, step_rem, step_quo, fin_res;
        logic [7:0]    nq, nr, dz, ov;

        for (genvar l = 0; l < N; l++) begin : g_l
            // Operand capture: magnitudes and per-lane exception flags.
            logic [W-1:0] la, lb;
            logic         sa, sb;
            assign la = vs2[l*W +: W];
            assign lb = vs1[l*W +: W];
            assign sa = is_signed & la[W-1];
            assign sb = is_signed & lb[W-1];
            assign abs_a[l*W +: W] = sa ? -la : la;
            assign abs_b[l*W +: W] = sb ? -lb : lb;
            assign nq[l] = sa ^ sb;
            assign nr[l] = sa;
            assign dz[l] = (lb == '0);
            assign ov[l] = is_signed & (la == {1'b1, {(W-1){1'b0}}}) & (&lb);

            // One restoring step: shift {rem, quo} left, trial-subtract in W+1 bits.
            // The borrow out of the subtraction is the inverted quotient bit.
            logic [W:0] trial, diff;
            assign trial = {rem_q[l*W +: W], quo_q[l*W+W-1]};
            assign diff  = trial - {1'b0, div_q[l*W +: W]};
            assign step_rem[l*W +: W] = diff[W] ? trial[W-1:0] : diff[W-1:0];
            assign step_quo[l*W +: W] = {quo_q[l*W +: W-1], ~diff[W]};

            // Final correction. Div-by-zero wins over everything, then overflow.
            logic [W-1:0] q, r, o, qc, rc;
            assign q  = quo_q[l*W +: W];
            assign r  = rem_q[l*W +: W];
            assign o  = orig_q[l*W +: W];
            assign qc = dz_q[l] ? '1 : (ov_q[l] ? o  : (nq_q[l] ? -q : q));
            assign rc = dz_q[l] ? o  : (ov_q[l] ? '0 : (nr_q[l] ? -r : r));
            assign fin_res[l*W +: W] = wr_q ? rc : qc;
        end

        if (N < 8) begin : g_pad
            assign nq[7:N] = '0;
            assign nr[7:N] = '0;
            assign dz[7:N] = '0;
            assign ov[7:N] = '0;
        end

        assign abs_a_w[g]    = abs_a;
        assign abs_b_w[g]    = abs_b;
        assign nq_w[g]       = nq;
        assign nr_w[g]       = nr;
        assign dz_w[g]       = dz;
        assign ov_w[g]       = ov;
        assign step_rem_w[g] = step_rem;
        assign step_quo_w[g] = step_quo;
        assign fin_res_w[g]  = fin_res;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_d = DIVIDE;
            end
            DIVIDE: begin
                if (cnt_q == 7'd1) state_d = FINISH;
            end
            FINISH: begin
                state_d = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sew_q  <= '0;
            wr_q   <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            orig_q <= '0;
            nq_q   <= '0;
            nr_q   <= '0;
            dz_q   <= '0;
            ov_q   <= '0;
            vd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        sew_q  <= sew;
                        wr_q   <= want_remainder;
                        rem_q  <= '0;
                        quo_q  <= abs_a_w[sew];
                        div_q  <= abs_b_w[sew];
                        orig_q <= vs2;
                        nq_q   <= nq_w[sew];
                        nr_q   <= nr_w[sew];
                        dz_q   <= dz_w[sew];
                        ov_q   <= ov_w[sew];
                        cnt_q  <= lane_bits(sew);
                    end
                end
                DIVIDE: begin
                    rem_q <= step_rem_w[sew_q];
                    quo_q <= step_quo_w[sew_q];
                    cnt_q <= cnt_q - 7'd1;
                end
                FINISH: begin
                    vd_q <= fin_res_w[sew_q];
                end
                default: ;
            endcase
        end
    end

    assign vd = vd_q;

endmodule

// File: tb/tb_vector_divide_unit.sv
// Bench for vector_divide_unit: directed vector table, backpressure and mid-operation reset
// sequences, then a random regression against a lane-wise RISC-V division model.
// Expected results go into a scoreboard queue on acceptance and are popped when vd appears.
module tb_vector_divide_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  sew;
    logic        is_signed;
    logic        want_remainder;
    logic [63:0] vs2;
    logic [63:0] vs1;
    logic        result_valid;
    logic        result_ready;
    logic [63:0] vd;

    always #5 clock = ~clock;

    vector_divide_unit #(.DATA_WIDTH(64)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .sew            (sew),
        .is_signed      (is_signed),
        .want_remainder (want_remainder),
        .vs2            (vs2),
        .vs1            (vs1),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .vd             (vd)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] vd;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [1:0]  sew;
        logic        sgn;
        logic        wr;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Lane-wise reference: RISC-V semantics including x/0 and most-negative/-1.
    function automatic logic [63:0] model(input logic [1:0] s, input logic sg, input logic wr,
                                          input logic [63:0] a, input logic [63:0] b);
        int          w, n;
        logic [63:0] mask, ua, ub, r, res;
        longint      sa, sb2;
        w    = 8 << s;
        n    = 64 / w;
        res  = '0;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        for (int l = 0; l < n; l++) begin
            ua  = (a >> (l * w)) & mask;
            ub  = (b >> (l * w)) & mask;
            sa  = longint'(ua << (64 - w)) >>> (64 - w);
            sb2 = longint'(ub << (64 - w)) >>> (64 - w);
            if (ub == 64'd0)
                r = wr ? ua : mask;
            else if (!sg)
                r = wr ? (ua % ub) : (ua / ub);
            else if (ua == (64'd1 << (w - 1)) && ub == mask)
                r = wr ? 64'd0 : ua;
            else
                r = wr ? 64'(sa % sb2) : 64'(sa / sb2);
            res = res | ((r & mask) << (l * w));
        end
        return res;
    endfunction

    // Entered just after the accepting posedge; leaves at the negedge where result_valid is seen.
    task automatic collect_result();
        int   lat;
        exp_t e;
        lat = 0;
        @(negedge clock);
        start_valid = 1'b0;
        while (!result_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        e = sb.pop_front();
        if (!result_valid) begin
            n_checks++;
            $display("FAIL %s_timeout: result_valid not seen within %0d cycles, expected %0d", e.name, lat, e.lat);
        end else begin
            check({e.name, "_lat"}, 64'(lat), 64'(e.lat));
            check(e.name, vd, e.vd);
        end
    endtask

    task automatic drive_and_accept(input logic [1:0] s, input logic sg, input logic wr,
                                    input logic [63:0] a, input logic [63:0] b, input logic rr,
                                    output bit ok);
        int t;
        @(negedge clock);
        sew = s; is_signed = sg; want_remainder = wr; vs2 = a; vs1 = b;
        start_valid = 1'b1;
        result_ready = rr;
        t = 0;
        while (!start_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        ok = start_ready;
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: start_ready low for %0d cycles, expected 1", t);
            start_valid = 1'b0;
        end else begin
            @(posedge clock);
        end
    endtask

    task automatic run_op(input logic [1:0] s, input logic sg, input logic wr,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                          input string name);
        bit ok;
        drive_and_accept(s, sg, wr, a, b, 1'b1, ok);
        if (ok) begin
            sb.push_back('{exp, (8 << s) + 1, name});
            collect_result();
        end
    endtask

    initial begin
        bit          ok;
        int          pulses;
        logic [1:0]  rs;
        logic        rsg, rwr;
        logic [63:0] ra, rb;

        vecs[0] = '{2'd3, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, "u64_quo"};
        vecs[1] = '{2'd3, 1'b0, 1'b1, 64'd100, 64'd7, 64'd2,  "u64_rem"};
        vecs[2] = '{2'd0, 1'b1, 1'b0, 64'h0000_0000_0005_80F9, 64'h0101_0101_0100_FF02,
                    64'h0000_0000_00FF_80FD, "s8_quo"};
        vecs[3] = '{2'd0, 1'b1, 1'b1, 64'h0000_0000_0005_80F9, 64'h0101_0101_0100_FF02,
                    64'h0000_0000_0005_00FF, "s8_rem"};
        vecs[4] = '{2'd2, 1'b1, 1'b1, 64'hFFFF_FFEC_0000_0014, 64'h0000_0006_FFFF_FFFA,
                    64'hFFFF_FFFE_0000_0002, "s32_rem"};
        vecs[5] = '{2'd2, 1'b1, 1'b0, 64'hFFFF_FFEC_0000_0014, 64'h0000_0006_FFFF_FFFA,
                    64'hFFFF_FFFD_FFFF_FFFD, "s32_quo"};
        // lane0 0x64/0, lane1 0xFFFF/3, lanes 2-3 0/1; unsigned never negates
        vecs[6] = '{2'd1, 1'b0, 1'b0, 64'h0000_0000_FFFF_0064, 64'h0001_0001_0003_0000,
                    64'h0000_0000_5555_FFFF, "u16_quo"};
        vecs[7] = '{2'd1, 1'b0, 1'b1, 64'h0000_0000_FFFF_0064, 64'h0001_0001_0003_0000,
                    64'h0000_0000_0000_0064, "u16_rem"};

        reset_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
        sew = '0; is_signed = 1'b0; want_remainder = 1'b0; vs2 = '0; vs1 = '0;
        repeat (3) @(negedge clock);
        check("rst_start_ready",  64'(start_ready),  64'd1);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_vd",           vd,                64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_start_ready", 64'(start_ready), 64'd1);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].sew, vecs[i].sgn, vecs[i].wr, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        // Backpressure: hold the consumer off while a new operation waits at the input.
        drive_and_accept(2'd3, 1'b0, 1'b0, 64'd100, 64'd7, 1'b0, ok);
        if (ok) begin
            sb.push_back('{64'd14, 65, "bp_first"});
            collect_result();
            vs2 = 64'h0000_03E8_0000_0064; vs1 = 64'h0000_000A_0000_0003;
            sew = 2'd2; is_signed = 1'b0; want_remainder = 1'b0;
            start_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                check("bp_vd_hold",      vd,                64'd14);
                check("bp_valid_hold",   64'(result_valid), 64'd1);
                check("bp_ready_low",    64'(start_ready),  64'd0);
            end
            result_ready = 1'b1;
            @(negedge clock);
            check("bp_valid_drop",  64'(result_valid), 64'd0);
            check("bp_idle_ready",  64'(start_ready),  64'd1);
            @(posedge clock);
            sb.push_back('{64'h0000_0064_0000_0021, 33, "bp_second"});
            #1;
            check("bp_accepted", 64'(start_ready), 64'd0);
            collect_result();
        end

        // Asynchronous reset in the middle of a 64-bit divide.
        drive_and_accept(2'd3, 1'b1, 1'b0, 64'h8123_4567_89AB_CDEF, 64'd12345, 1'b1, ok);
        if (ok) begin
            @(negedge clock);
            start_valid = 1'b0;
            repeat (19) @(posedge clock);
            #2;
            reset_n = 1'b0;
            #1;
            check("mid_rst_start_ready",  64'(start_ready),  64'd1);
            check("mid_rst_result_valid", 64'(result_valid), 64'd0);
            check("mid_rst_vd",           vd,                64'd0);
            pulses = 0;
            repeat (3) begin
                @(negedge clock);
                if (result_valid) pulses++;
            end
            reset_n = 1'b1;
            repeat (70) begin
                @(negedge clock);
                if (result_valid) pulses++;
            end
            check("mid_rst_no_result", 64'(pulses), 64'd0);
            check("mid_rst_ready_after", 64'(start_ready), 64'd1);
            // lane0 0xFF/0x10 = 0x000F; lanes 1-3 are 0/0 and return all ones
            run_op(2'd1, 1'b0, 1'b0, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0010,
                   64'hFFFF_FFFF_FFFF_000F, "post_rst_op");
        end

        for (int i = 0; i < 1000; i++) begin
            rs  = 2'($urandom_range(0, 3));
            rsg = 1'($urandom_range(0, 1));
            rwr = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = rb >> $urandom_range(0, 63);
                1: rb = rb & {$urandom, $urandom} & {$urandom, $urandom};
                2: begin
                    case (rs)
                        2'd0:    ra = 64'h8080_8080_8080_8080;
                        2'd1:    ra = 64'h8000_8000_8000_8000;
                        2'd2:    ra = 64'h8000_0000_8000_0000;
                        default: ra = 64'h8000_0000_0000_0000;
                    endcase
                    rb = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                3: rb = rb & 64'h0F0F_0F0F_0F0F_0F0F;
                default: ;
            endcase
            run_op(rs, rsg, rwr, ra, rb, model(rs, rsg, rwr, ra, rb), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
